// File: rtl/speed_switch_requester_if.sv
// Handshake and IO-register bus between the CPU-side speed switch requester,
// the CPU core, the clock module and the IO-register bus.
interface speed_switch_requester_if;
   logic        switch_req;
   logic        cpu_halt;
   logic        switch_done;
   logic        switch_err;
   logic [15:0] ioreg_addr;
   logic        ioreg_we_l;
   logic        ioreg_re_l;
   logic        disable_controller;
   logic        is_in_double_speedmode;

   modport master (
      input  switch_req,
      input  disable_controller,
      input  is_in_double_speedmode,
      output cpu_halt,
      output switch_done,
      output switch_err,
      output ioreg_addr,
      output ioreg_we_l,
      output ioreg_re_l
   );

   modport slave (
      output switch_req,
      output disable_controller,
      output is_in_double_speedmode,
      input  cpu_halt,
      input  switch_done,
      input  switch_err,
      input  ioreg_addr,
      input  ioreg_we_l,
      input  ioreg_re_l
   );
endinterface

// File: rtl/speed_switch_requester.sv
// CPU-side initiator of the CGB double-speed switch: writes the KEY1 prepare
// bit, holds the CPU through the clock module countdown, reads KEY1 back and
// verifies that the speed flipped before releasing the CPU.
module speed_switch_requester #(
   parameter logic [15:0] P_KEY1_ADDR = 16'hFF4D,
   parameter int unsigned P_WR_CYCLES = 8,
   parameter int unsigned P_RD_CYCLES = 8,
   parameter int unsigned P_TIMEOUT   = 1023
) (
   input  logic                      clk,
   input  logic                      sync_reset,
   speed_switch_requester_if.master  bus,
   inout  wire  [7:0]                ioreg_data
);

   localparam int unsigned CNT_W = 10;
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(P_WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(P_RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(P_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_KEY1,
      WAIT_DIS_HI,
      WAIT_DIS_LO,
      RD_KEY1,
      CHECK,
      RELEASE
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              spd0, spd0_nxt;
   logic              rd_bit, rd_bit_nxt;
   logic              halt_q, halt_nxt;
   logic              done_q, done_nxt;
   logic              err_q, err_nxt;
   logic [15:0]       addr_q, addr_nxt;
   logic              we_l_q, we_l_nxt;
   logic              re_l_q, re_l_nxt;
   logic              drive_q, drive_nxt;
   logic              verify_ok_c;

   // Speed must have flipped both in the KEY1 readback and on the live flag
   assign verify_ok_c = (rd_bit == ~spd0) && (bus.is_in_double_speedmode == ~spd0);

   // State and registered outputs; reset is applied last so it wins mid-transfer
   always_ff @(posedge clk) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      spd0   <= spd0_nxt;
      rd_bit <= rd_bit_nxt;
      halt_q <= halt_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      addr_q <= addr_nxt;
      we_l_q <= we_l_nxt;
      re_l_q <= re_l_nxt;
      drive_q <= drive_nxt;
      if (sync_reset) begin
         state   <= IDLE;
         cnt     <= '0;
         spd0    <= 1'b0;
         rd_bit  <= 1'b0;
         halt_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= 16'h0000;
         we_l_q  <= 1'b1;
         re_l_q  <= 1'b1;
         drive_q <= 1'b0;
      end
   end

   // Next state and the shared transfer / timeout counter
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (bus.switch_req) state_nxt = WR_KEY1;
         end
         WR_KEY1: begin
            if (cnt == WR_LAST) begin
               state_nxt = WAIT_DIS_HI;
               cnt_nxt   = '0;
            end
         end
         WAIT_DIS_HI: begin
            if (bus.disable_controller) begin
               state_nxt = WAIT_DIS_LO;
               cnt_nxt   = '0;
            end else if (cnt == TO_LAST) begin
               state_nxt = RELEASE;
               cnt_nxt   = '0;
            end
         end
         WAIT_DIS_LO: begin
            if (!bus.disable_controller) begin
               state_nxt = RD_KEY1;
               cnt_nxt   = '0;
            end else if (cnt == TO_LAST) begin
               state_nxt = RELEASE;
               cnt_nxt   = '0;
            end
         end
         RD_KEY1: begin
            if (cnt == RD_LAST) begin
               state_nxt = CHECK;
               cnt_nxt   = '0;
            end
         end
         CHECK: begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
         end
         RELEASE: begin
            cnt_nxt = '0;
            if (!bus.switch_req) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Next values of the registered outputs; bus strobes follow the next state
   always_comb begin
      spd0_nxt   = spd0;
      rd_bit_nxt = rd_bit;
      halt_nxt   = halt_q;
      done_nxt   = 1'b0;
      err_nxt    = err_q;
      we_l_nxt   = (state_nxt != WR_KEY1);
      re_l_nxt   = (state_nxt != RD_KEY1);
      drive_nxt  = (state_nxt == WR_KEY1);
      addr_nxt   = ((state_nxt == WR_KEY1) || (state_nxt == RD_KEY1)) ? P_KEY1_ADDR : 16'h0000;
      case (state)
         IDLE: begin
            if (bus.switch_req) begin
               spd0_nxt = bus.is_in_double_speedmode;
               err_nxt  = 1'b0;
               halt_nxt = 1'b1;
            end
         end
         WAIT_DIS_HI, WAIT_DIS_LO: begin
            if (state_nxt == RELEASE) begin
               err_nxt  = 1'b1;
               halt_nxt = 1'b0;
            end
         end
         RD_KEY1: begin
            if (cnt == RD_LAST) rd_bit_nxt = ioreg_data[7];
         end
         CHECK: begin
            halt_nxt = 1'b0;
            if (verify_ok_c) done_nxt = 1'b1;
            else             err_nxt  = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.cpu_halt    = halt_q;
   assign bus.switch_done = done_q;
   assign bus.switch_err  = err_q;
   assign bus.ioreg_addr  = addr_q;
   assign bus.ioreg_we_l  = we_l_q;
   assign bus.ioreg_re_l  = re_l_q;
   assign ioreg_data      = drive_q ? 8'h01 : 8'bz;

endmodule
